// File: rtl/queue_stream_out_pkg.sv
// Shared constants and types for the queue read-side stream adapter.
package queue_stream_out_pkg;

   // Output buffer depth; the credit limit on outstanding words equals this.
   localparam int STREAM_BUF_DEPTH   = 2;

   // Default entry width, matching the queue instance in the top level.
   localparam int DEFAULT_DATA_WIDTH = 32;

   // Occupancy of the output buffer (0..STREAM_BUF_DEPTH).
   typedef logic [1:0] buf_count_t;

endpackage

// File: rtl/queue_stream_out_stream_skid2.sv
// Two-entry register buffer. head_q drives the stream data directly so the
// consumer sees a registered word; tail_q holds the second word under
// backpressure. Push and pop may happen in the same cycle.
module stream_skid2
   import queue_stream_out_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output buf_count_t            count
);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   buf_count_t            count_q, count_d;

   // Next-state: the new word lands in head when the buffer is (or becomes)
   // empty of older words, otherwise behind them in tail.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = push_data;
            else                 tail_d = push_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Pop requires count >= 1, so only counts 1 and 2 reach here.
            if (count_q == 2'd1) begin
               head_d = push_data;
            end else begin
               head_d = tail_q;
               tail_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // Buffer registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_data = head_q;
   assign count     = count_q;

endmodule

// File: rtl/queue_stream_out.sv
// Read side of the queue presented as a valid/ready stream. Issues the
// queue's dequeue strobe on credit, tracks the one word in flight through
// the registered RAM read, and captures it into a 2-entry buffer so a
// stalled consumer never causes a fetched word to be dropped.
module queue_stream_out
   import queue_stream_out_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  q_empty,
   input  logic [DATA_WIDTH-1:0] q_data,
   output logic                  q_dequeue,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output buf_count_t            count
);

   // Handshake: a word transfers on a rising edge where m_valid && m_ready;
   // m_valid never depends on m_ready and m_data holds while stalled.

   logic       inflight_q, inflight_d;
   logic       pop;
   logic [2:0] credit_use;

   // Credit: words buffered plus in flight, less the one leaving this cycle,
   // must stay below the buffer depth before another read is issued.
   always_comb begin
      pop        = m_valid && m_ready;
      credit_use = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
      q_dequeue  = !reset && !q_empty && (credit_use < 3'(STREAM_BUF_DEPTH));
      inflight_d = q_dequeue;
   end

   // The read issued this cycle returns q_data next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) inflight_q <= 1'b0;
      else       inflight_q <= inflight_d;
   end

   stream_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (q_data),
      .pop       (pop),
      .head_data (m_data),
      .count     (count)
   );

   assign m_valid = (count != 2'd0);

   a_count_max : assert property (@(posedge clk) disable iff (reset)
      count <= 2'(STREAM_BUF_DEPTH));

   a_credit : assert property (@(posedge clk) disable iff (reset)
      ({1'b0, count} + {2'b00, inflight_q}) <= 3'(STREAM_BUF_DEPTH));

   a_deq_nonempty : assert property (@(posedge clk) disable iff (reset)
      q_dequeue |-> !q_empty);

   a_hold : assert property (@(posedge clk) disable iff (reset)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_queue_stream_out.sv
// Directed bench for queue_stream_out with a behavioural registered-read
// queue in front of it.
module tb_queue_stream_out;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         q_empty;
   logic [W-1:0] q_data = '0;
   logic         q_dequeue;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic [1:0]   count;

   logic [W-1:0] mem [0:1023];
   int           wr_ptr = 0;
   int           rd_ptr = 0;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] w3 [3];

   // clock
   always #5 clk = ~clk;

   queue_stream_out #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .q_empty   (q_empty),
      .q_data    (q_data),
      .q_dequeue (q_dequeue),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .count     (count)
   );

   // Upstream queue model: registered read, data one cycle after dequeue.
   assign q_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (q_dequeue) begin
         q_data <= mem[rd_ptr % 1024];
         rd_ptr <= rd_ptr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [W-1:0] v);
      mem[wr_ptr % 1024] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Dequeue must never be issued against an empty queue.
   always @(negedge clk) begin
      if (!reset) chk("deq_on_empty", {31'b0, q_dequeue && q_empty}, 32'd0);
   end

   initial begin
      int sent;
      int got;
      int cyc;
      int found;
      int pulses;
      int vcyc;
      logic deq_e;
      logic [1:0] cnt_e;

      w3[0] = 32'h11;
      w3[1] = 32'h22;
      w3[2] = 32'h33;

      // Reset with a word available: dequeue must still be held low.
      reset   = 1'b1;
      m_ready = 1'b0;
      push_word(32'hDEAD);
      repeat (3) begin
         tick();
         #1;
         chk("rst_deq", {31'b0, q_dequeue}, 32'd0);
         chk("rst_valid", {31'b0, m_valid}, 32'd0);
         chk("rst_count", {30'b0, count}, 32'd0);
         chk("rst_data", m_data, 32'd0);
      end
      wr_ptr = rd_ptr;
      tick();
      reset = 1'b0;

      // Idle with empty queue.
      repeat (20) begin
         tick();
         #1;
         chk("idle_deq", {31'b0, q_dequeue}, 32'd0);
         chk("idle_valid", {31'b0, m_valid}, 32'd0);
         chk("idle_count", {30'b0, count}, 32'd0);
      end

      // Three words, consumer always ready.
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) push_word(w3[i]);
      #1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin
            tick();
            #1;
         end
         chk("rdy_deq", {31'b0, q_dequeue}, {31'b0, c <= 2});
         chk("rdy_valid", {31'b0, m_valid}, {31'b0, c >= 2 && c <= 4});
         chk("rdy_count", {30'b0, count}, (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
         if (c >= 2 && c <= 4) chk("rdy_data", m_data, w3[c-2]);
      end
      repeat (3) tick();

      // Three words, consumer stalled until cycle 10.
      tick();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_word(w3[i]);
      #1;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) begin
            tick();
            if (c == 10) m_ready = 1'b1;
            #1;
         end
         deq_e = (c <= 1) || (c == 10);
         if (c < 2 || c == 13)      cnt_e = 2'd0;
         else if (c <= 10)          cnt_e = 2'd2;
         else                       cnt_e = 2'd1;
         if (c == 2) cnt_e = 2'd1;
         chk("bp_deq", {31'b0, q_dequeue}, {31'b0, deq_e});
         chk("bp_count", {30'b0, count}, {30'b0, cnt_e});
         chk("bp_valid", {31'b0, m_valid}, {31'b0, cnt_e != 2'd0});
         if (c >= 2 && c <= 10) chk("bp_data_hold", m_data, 32'h11);
         if (c == 11)           chk("bp_data_1", m_data, 32'h22);
         if (c == 12)           chk("bp_data_2", m_data, 32'h33);
      end
      repeat (3) tick();

      // 256 incrementing words, bursty supply and random backpressure.
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 256 && cyc < 4000) begin
         tick();
         if (sent < 256 && $urandom_range(0, 3) != 0) begin
            push_word(32'h1000 + sent);
            exp_q.push_back(32'h1000 + sent);
            sent++;
         end
         m_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (m_valid && m_ready) begin
            if (exp_q.size() > 0) chk("stream_word", m_data, exp_q.pop_front());
            else                  chk("stream_extra", exp_q.size(), 32'd1);
            got++;
         end
         cyc++;
      end
      chk("stream_got", got, 32'd256);
      chk("stream_left", exp_q.size(), 32'd0);
      m_ready = 1'b1;
      repeat (4) tick();
      #1;
      chk("stream_extra_out", {31'b0, m_valid}, 32'd0);

      // Reset with one word buffered and one in flight.
      tick();
      m_ready = 1'b0;
      push_word(32'hC1);
      push_word(32'hC2);
      push_word(32'hC3);
      tick();
      tick();
      #1;
      chk("mid_pre_count", {30'b0, count}, 32'd1);
      reset  = 1'b1;
      wr_ptr = rd_ptr;
      #1;
      chk("mid_valid", {31'b0, m_valid}, 32'd0);
      chk("mid_count", {30'b0, count}, 32'd0);
      chk("mid_data", m_data, 32'd0);
      chk("mid_deq", {31'b0, q_dequeue}, 32'd0);
      tick();
      reset   = 1'b0;
      m_ready = 1'b1;
      push_word(32'hAB);
      #1;
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
         if (m_valid) begin
            chk("mid_first", m_data, 32'hAB);
            found = 1;
         end else begin
            tick();
            #1;
         end
      end
      chk("mid_seen", found, 32'd1);
      repeat (4) tick();

      // Single word: one dequeue pulse, one valid cycle.
      tick();
      m_ready = 1'b1;
      push_word(32'h5A);
      #1;
      pulses = 0;
      vcyc   = 0;
      for (int c = 0; c < 8; c++) begin
         if (q_dequeue) pulses++;
         if (m_valid) begin
            vcyc++;
            chk("one_data", m_data, 32'h5A);
         end
         tick();
         #1;
      end
      chk("one_deq", pulses, 32'd1);
      chk("one_valid", vcyc, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
